// File: rtl/imc_arb_pkg.sv
// Shared types and default widths for the IMC round-robin arbiter.
// Pure declarations: no logic, no latency, no flow control.
package imc_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RES_W  = 32;

endpackage

// File: rtl/imc_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Zero latency; no backpressure, purely a function of req and ptr.
module rr_pick
    import imc_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any_req
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
        any_req = found;
    end

endmodule

// File: rtl/imc_arbiter.sv
// Shares one IMC unit among N_REQ requesters with round-robin grants.
// Grant edge -> start/ack next cycle; done returns one cycle after imc_done.
// Requesters hold until req_ack; imc_ready gates grants only while idle.
module imc_arbiter
    import imc_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*DATA_W-1:0] req_c,
    input  logic [N_REQ*DATA_W-1:0] req_d,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        req_done,
    output logic [RES_W-1:0]        res_out,
    input  logic                    imc_ready,
    input  logic                    imc_done,
    input  logic [RES_W-1:0]        imc_result,
    output logic                    imc_start,
    output logic [DATA_W-1:0]       a,
    output logic [DATA_W-1:0]       b,
    output logic [DATA_W-1:0]       c,
    output logic [DATA_W-1:0]       d,
    output logic                    busy
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] d;
    } opnd_t;

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any;
    logic [N_REQ-1:0] done_q;
    opnd_t            opnd_sel;
    opnd_t            opnd_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    // One-hot AND-OR mux keeps the operand select flat regardless of N_REQ.
    always_comb begin
        opnd_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                opnd_sel.a = opnd_sel.a | req_a[i*DATA_W +: DATA_W];
                opnd_sel.b = opnd_sel.b | req_b[i*DATA_W +: DATA_W];
                opnd_sel.c = opnd_sel.c | req_c[i*DATA_W +: DATA_W];
                opnd_sel.d = opnd_sel.d | req_d[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            opnd_q  <= '0;
            res_out <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (imc_ready && pick_any) begin
                        state   <= ISSUE;
                        gnt_idx <= pick_idx;
                        opnd_q  <= opnd_sel;
                        ptr     <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
                    end
                end
                ISSUE: state <= BUSY;
                BUSY: begin
                    if (imc_done) begin
                        state   <= IDLE;
                        res_out <= imc_result;
                        done_q  <= N_REQ'(1) << gnt_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imc_start = (state == ISSUE);
    assign req_ack   = imc_start ? (N_REQ'(1) << gnt_idx) : '0;
    assign req_done  = done_q;
    assign busy      = (state != IDLE);
    assign a         = opnd_q.a;
    assign b         = opnd_q.b;
    assign c         = opnd_q.c;
    assign d         = opnd_q.d;

endmodule

// File: doc/imc_arbiter.md
# imc_arbiter

Round-robin scheduler that shares one IMC compute unit between `N_REQ` input wrappers. Each wrapper presents a complete operand set (a, b, c, d) with a request. The arbiter grants one request, latches its operands, and issues a single-cycle start to the IMC. It then waits for completion and returns the result and a done pulse to the granted wrapper only. It sits between the input-wrapper instances and the IMC, replacing their direct `imc_start`/`imc_ready` connection.

## Interface
- `N_REQ`, default 2: number of requesters (≥2).
- `DATA_W`, default 16: operand width.
- `RES_W`, default 32: IMC result width.
- Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  request i pending; operands valid while high.
- `req_a`, `req_b`, `req_c`, `req_d`  in  N_REQ×DATA_W  packed operands per requester.
- `req_ack`  out  N_REQ  one-cycle pulse: operands of requester i captured.
- `req_done`  out  N_REQ  one-cycle pulse: result for requester i valid.
- `res_out`  out  RES_W  result; valid with any `req_done` bit, held until next completion.
- `imc_ready`  in  1  IMC idle, can accept start.
- `imc_done`  in  1  IMC completion pulse.
- `imc_result`  in  RES_W  valid while `imc_done`=1.
- `imc_start`  out  1  one-cycle start pulse.
- `a`, `b`, `c`, `d`  out  DATA_W  registered operands to IMC.
- `busy`  out  1  arbiter not in IDLE.

## Operation
- States:
  - IDLE: wait for work.
  - ISSUE: start the IMC.
  - BUSY: wait for IMC completion.
- IDLE → ISSUE when `imc_ready`=1 and any `req_valid` bit is set.
  - Grant g = first set bit searching from `ptr` upward, modulo N_REQ.
  - On this edge: latch g, latch req_*[g] into a..d, set `ptr` ← (g+1) mod N_REQ.
- ISSUE → BUSY unconditionally. During ISSUE: `imc_start`=1, `req_ack[g]`=1, a..d stable.
- BUSY → IDLE on `imc_done`=1. On this edge: `res_out` ← `imc_result`, `req_done[g]` ← 1 for one cycle.
- Requester protocol:
  - Requester holds `req_valid` and operands stable until `req_ack`.
  - Requester drops `req_valid` on the cycle after the ack, or keeps it high to queue its next operation.
  - Withdrawal before the grant edge is legal; withdrawal after the grant has no effect, because the operands are already latched.
- `imc_done` outside BUSY is ignored.
- `imc_ready` is sampled only in IDLE.
- a..d hold their last value outside ISSUE/BUSY. They change only on a grant edge.
- No arithmetic on data. `ptr` is ⌈log2 N_REQ⌉ bits and wraps N_REQ-1 → 0.

## Timing
- Reset (asynchronous, immediate) puts the block in this state:
  - state IDLE, `ptr`=0, g=0;
  - a..d=0, `res_out`=0;
  - `imc_start`=0, `req_ack`=0, `req_done`=0, `busy`=0.
- Reset during BUSY abandons the in-flight operation. A later `imc_done` is ignored, because the block is then in IDLE.
- Timing from a request seen in IDLE at edge t (with `imc_ready`=1):
  - `imc_start` and `req_ack[g]` are high in cycle t+1;
  - `busy` is high from t+1.
- If `imc_done` is high at edge u (u ≥ t+2), `req_done[g]` and the new `res_out` are visible in cycle u+1. The state is IDLE in u+1, so a new grant can occur at edge u+1.
- Minimum request-to-request spacing: 3 cycles plus IMC latency.
- Simultaneous requests are resolved by `ptr` alone, with no starvation. A requester waits at most N_REQ-1 grants.
- A request arriving in the same cycle as `imc_done` is considered at the next IDLE edge.

## Structure
- Package `imc_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t`;
  - default DATA_W/RES_W localparams.
- Sub-module `rr_pick`:
  - combinational round-robin priority pick;
  - inputs: request vector, `ptr`;
  - outputs: one-hot grant, grant index, any-valid.
- Top: state register, grant/ptr registers, operand mux and capture registers, result register.

## Test plan
- Reset mid-BUSY:
  - stimulus: grant req0, assert `rst` before `imc_done`, then pulse `imc_done`;
  - required: all outputs 0 immediately, no `req_done`, `busy`=0.
- Single request:
  - stimulus: req0 with a=0x0001, b=0x0002, c=0x0003, d=0x0004, IMC done 4 cycles after start with result 0x0000_0021;
  - required: `imc_start`/`req_ack[0]` one cycle, a..d=0x0001..0x0004, `req_done[0]` one cycle, `res_out`=0x21, `req_done[1]` never.
- Contention:
  - stimulus: req0 and req1 both held high from reset release;
  - required: grant order 0,1,0,1 over four operations; each `req_done` goes to the matching index.
- `imc_ready` low:
  - stimulus: req1 high while `imc_ready`=0 for 5 cycles;
  - required: no `imc_start` until the cycle after `imc_ready` rises.
- Spurious done:
  - stimulus: `imc_done` pulsed in IDLE and in ISSUE;
  - required: no `req_done`, `res_out` unchanged.
- Back-to-back:
  - stimulus: `imc_done` and a new req0 in the same cycle;
  - required: `req_done` in cycle u+1, new `imc_start` in cycle u+2.
